lsu: RTL and testbench

Load/store unit between the execute stage and dmem. It accepts one memory request per handshake, validates funct3, alignment and range, and drives the dmem control/address/data pins. It captures dmem read data, applies RV32 sign/zero extension, and holds the result until the pipeline consumes it.

---
 rtl/echo_mem_pkg.sv | 19 +
 rtl/lsu_load_ext.sv | 16 +
 rtl/lsu.sv | 91 +++++++++
 tb/tb_lsu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/echo_mem_pkg.sv
// echo_mem_pkg: shared codes for the load/store unit and dmem.
package echo_mem_pkg;
    localparam logic [1:0] SIZE_8  = 2'b00;
    localparam logic [1:0] SIZE_16 = 2'b01;
    localparam logic [1:0] SIZE_32 = 2'b10;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b11;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: RV32 load sign/zero extension of raw dmem read data.
module lsu_load_ext
    import echo_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);
    always_comb
        data = funct3 == F3_LB  ? {{(XLEN-8){raw[7]}}, raw[7:0]} :
               funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, raw[7:0]} :
               funct3 == F3_LH  ? {{(XLEN-16){raw[15]}}, raw[15:0]} :
               funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, raw[15:0]} : raw;
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit; validates requests, drives dmem pins, returns extended load data.
module lsu
    import echo_mem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DMEM_BYTES = 2048
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [1:0]      rsp_err,
    output logic            mem_en,
    output logic            mem_write,
    output logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);
    state_t          state, state_nx;
    logic [2:0]      f3_q;
    logic            wr_q;
    logic [1:0]      err_q, err;
    logic            illegal, misal, rng_err;
    logic [XLEN:0]   end_addr;
    logic [XLEN-1:0] ext;

    lsu_load_ext #(.XLEN(XLEN)) u_ext (.funct3(f3_q), .raw(mem_rdata), .data(ext));

    assign req_ready = state == IDLE;

    // Loads always fetch a full word from dmem, so their range check uses 4 bytes.
    always_comb begin
        illegal  = req_write ? !(req_funct3 inside {F3_SB, F3_SH, F3_SW})
                             : !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        misal    = (req_funct3[1:0] == SIZE_16 && req_addr[0]) ||
                   (req_funct3[1:0] == SIZE_32 && req_addr[1:0] != 2'b00);
        end_addr = {1'b0, req_addr} + (req_write ? (XLEN+1)'(1) << req_funct3[1:0] : (XLEN+1)'(4));
        rng_err  = end_addr > (XLEN+1)'(DMEM_BYTES);
        err      = illegal ? ERR_F3 : misal ? ERR_MISAL : rng_err ? ERR_RANGE : ERR_OK;
        state_nx = state == IDLE   ? (req_valid ? ACCESS : IDLE) :
                   state == ACCESS ? RESP : (rsp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // Errors also spend the ACCESS cycle (with dmem idle) so every response has equal latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q      <= '0;
            wr_q      <= 1'b0;
            err_q     <= ERR_OK;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_size  <= SIZE_8;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE && req_valid) begin
            f3_q  <= req_funct3;
            wr_q  <= req_write;
            err_q <= err;
            if (err == ERR_OK) begin
                mem_en    <= 1'b1;
                mem_write <= req_write;
                mem_size  <= req_funct3[1:0];
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
        end else if (state == ACCESS) begin
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= (wr_q || err_q != ERR_OK) ? '0 : ext;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu with a negedge dmem and a byte-array reference model.
module tb_lsu;
    localparam int DMEM_BYTES = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, mem_en, mem_write;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  rsp_err, mem_size;

    logic [7:0] dmem [DMEM_BYTES];
    logic [7:0] ref_mem [DMEM_BYTES];
    int n_tests = 0, n_fail = 0, en_cnt = 0;

    lsu #(.XLEN(32), .DMEM_BYTES(DMEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // dmem: acts on the falling edge, reads 4 bytes little-endian, writes 1<<size bytes
    always @(negedge clk) begin
        logic [31:0] rd;
        if (mem_en) begin
            en_cnt++;
            if (mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (i < (1 << mem_size) && mem_addr + 32'(i) < DMEM_BYTES)
                        dmem[mem_addr + 32'(i)] <= mem_wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < 4; i++)
                    rd[8*i +: 8] = (mem_addr + 32'(i) < DMEM_BYTES) ? dmem[mem_addr + 32'(i)] : 8'h00;
                mem_rdata <= rd;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {err, data} from the RV32 rules applied to the reference byte image.
    function automatic logic [33:0] predict(input logic w, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int sz, b, h;
        longint need;
        logic [1:0] e;
        logic [31:0] d;
        legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz = 1 << f3[1:0];
        need = w ? sz : 4;
        if (!legal) e = 2'd2;
        else if (a % sz != 0) e = 2'd1;
        else if (longint'({32'b0, a}) + need > DMEM_BYTES) e = 2'd3;
        else e = 2'd0;
        d = '0;
        if (e == 0 && !w) begin
            b = int'(ref_mem[a]);
            h = b + 256 * int'(ref_mem[a + 1]);
            case (f3)
                3'd0: d = b >= 128 ? 32'(b - 256) : 32'(b);
                3'd4: d = 32'(b);
                3'd1: d = h >= 32768 ? 32'(h - 65536) : 32'(h);
                3'd5: d = 32'(h);
                default: d = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
            endcase
        end
        return {e, d};
    endfunction

    task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] ee, input logic [31:0] ed, input int hold);
        int e0;
        @(posedge clk); #1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        e0 = en_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        check("rsp_early", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_err", 32'(rsp_err), 32'(ee));
        check("rsp_rdata", rsp_rdata, ed);
        check("mem_en_count", 32'(en_cnt - e0), (ee == 2'd0) ? 32'd1 : 32'd0);
        check("mem_en_low", 32'(mem_en), 32'd0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, ed);
            check("hold_err", 32'(rsp_err), 32'(ee));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
        if (w && ee == 2'd0)
            for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    initial begin
        logic [33:0] p;
        logic [31:0] a;
        logic [2:0]  f3;
        logic        w;
        int bad;
        for (int i = 0; i < DMEM_BYTES; i++) begin dmem[i] = 8'h00; ref_mem[i] = 8'h00; end
        dmem[16] = 8'h80; dmem[17] = 8'h7F; dmem[18] = 8'h01; dmem[19] = 8'hFF;
        ref_mem[16] = 8'h80; ref_mem[17] = 8'h7F; ref_mem[18] = 8'h01; ref_mem[19] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        xact(0, 3'd2, 32'h10, 0, 2'd0, 32'hFF017F80, 0);
        xact(0, 3'd0, 32'h10, 0, 2'd0, 32'hFFFFFF80, 0);
        xact(0, 3'd4, 32'h10, 0, 2'd0, 32'h00000080, 0);
        xact(0, 3'd1, 32'h10, 0, 2'd0, 32'h00007F80, 0);
        xact(0, 3'd5, 32'h12, 0, 2'd0, 32'h0000FF01, 0);
        xact(1, 3'd1, 32'h20, 32'hDEADBEEF, 2'd0, 32'h0, 0);
        xact(0, 3'd2, 32'h20, 0, 2'd0, 32'h0000BEEF, 0);
        xact(1, 3'd0, 32'h23, 32'h12345678, 2'd0, 32'h0, 0);
        xact(0, 3'd2, 32'h20, 0, 2'd0, 32'h7800BEEF, 5);
        xact(0, 3'd2, 32'h22, 0, 2'd1, 32'h0, 0);
        xact(0, 3'd1, 32'h21, 0, 2'd1, 32'h0, 0);
        xact(0, 3'd3, 32'h10, 0, 2'd2, 32'h0, 0);
        xact(0, 3'd2, 32'h7FE, 0, 2'd1, 32'h0, 0);
        xact(0, 3'd2, 32'h800, 0, 2'd3, 32'h0, 0);
        xact(0, 3'd0, 32'h7FD, 0, 2'd3, 32'h0, 0);
        xact(1, 3'd3, 32'h30, 32'h1, 2'd2, 32'h0, 0);
        xact(1, 3'd0, 32'h7FF, 32'hA5, 2'd0, 32'h0, 0);
        xact(0, 3'd2, 32'h7FC, 0, 2'd0, 32'hA5000000, 0);
        xact(1, 3'd1, 32'h7FE, 32'h1234, 2'd0, 32'h0, 0);
        xact(0, 3'd2, 32'h7FC, 0, 2'd0, 32'h12340000, 0);
        xact(1, 3'd2, 32'h800, 32'h1, 2'd3, 32'h0, 0);

        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            a  = ($urandom % 10 == 0) ? $urandom : $urandom_range(0, DMEM_BYTES + 7);
            if ($urandom % 2 == 1) a = a & ~32'h3;
            p = predict(w, f3, a);
            xact(w, f3, a, $urandom, p[33:32], p[31:0], int'($urandom % 3));
        end

        // reset while a store sits in ACCESS: dmem must never see it
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'hAAAAAAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_mem_en", 32'(mem_en), 32'd0);
        check("arst_mem_write", 32'(mem_write), 32'd0);
        check("arst_mem_size", 32'(mem_size), 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_mem_wdata", mem_wdata, 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_rdata", rsp_rdata, 32'd0);
        check("arst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("arst_target", {dmem[67], dmem[66], dmem[65], dmem[64]},
              {ref_mem[67], ref_mem[66], ref_mem[65], ref_mem[64]});
        p = predict(1'b0, 3'd2, 32'h40);
        xact(0, 3'd2, 32'h40, 0, p[33:32], p[31:0], 1);

        bad = 0;
        for (int i = 0; i < DMEM_BYTES; i++) if (dmem[i] !== ref_mem[i]) bad++;
        check("mem_image_bad_bytes", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
